// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - register-file write port arbiter: WB priority, queued LLU results
module regfile_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_wen,
  input  logic [4:0]  wb_addr,
  input  logic [63:0] wb_data,
  input  logic        llu_valid,
  output logic        llu_ready,
  input  logic [4:0]  llu_addr,
  input  logic [63:0] llu_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        pend_rs1,
  output logic        pend_rs2,
  output logic        stall_req,
  output logic        rd_wen,
  output logic [4:0]  rd_addr,
  output logic [63:0] rd_data
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, STARVE} state_t;

  logic [4:0]       q_addr [DEPTH];
  logic [63:0]      q_data [DEPTH];
  logic [DEPTH-1:0] q_live;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  state_t           state, state_nx;
  logic [SCW-1:0]   starve_cnt, starve_cnt_nx;

  logic wb_sel, head_valid, head_live, pop, pop_live, push, blocked, others_live;
  logic [DEPTH-1:0] others_mask;

  // A live entry is always inside the occupied window, so q_live alone identifies pending writes.
  assign llu_ready  = (count != CW'(DEPTH));
  assign wb_sel     = wb_wen && (wb_addr != 5'd0);
  assign head_valid = (count != '0);
  assign head_live  = q_live[rd_ptr];
  assign pop_live   = head_live && !wb_sel;
  assign pop        = head_valid && (!head_live || !wb_sel);
  assign push       = llu_valid && llu_ready && (llu_addr != 5'd0);
  assign blocked    = head_live && wb_sel;
  assign stall_req  = (state == STARVE);

  always_comb begin
    others_mask         = q_live;
    others_mask[rd_ptr] = 1'b0;
  end
  assign others_live = |others_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_live  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_wen  <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else begin
      // WAW kill first; a same-cycle push to the same address is younger and survives.
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_sel && (q_addr[i] == wb_addr)) q_live[i] <= 1'b0;
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + AW'(1);
      end
      if (push) begin
        q_addr[wr_ptr] <= llu_addr;
        q_data[wr_ptr] <= llu_data;
        q_live[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      count  <= count + CW'(push) - CW'(pop);
      rd_wen <= wb_sel || pop_live;
      if (wb_sel) begin
        rd_addr <= wb_addr;
        rd_data <= wb_data;
      end else if (pop_live) begin
        rd_addr <= q_addr[rd_ptr];
        rd_data <= q_data[rd_ptr];
      end else begin
        rd_addr <= '0;
        rd_data <= '0;
      end
    end
  end

  function automatic logic pend_match(input logic [4:0] rs);
    logic hit;
    hit = (rd_wen && (rd_addr == rs)) || (push && (llu_addr == rs));
    for (int i = 0; i < DEPTH; i++) begin
      if (q_live[i] && (q_addr[i] == rs)) hit = 1'b1;
    end
    return hit && (rs != 5'd0);
  endfunction

  assign pend_rs1 = pend_match(rs1_addr);
  assign pend_rs2 = pend_match(rs2_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= starve_cnt_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    starve_cnt_nx = starve_cnt;
    case (state)
      IDLE: begin
        starve_cnt_nx = '0;
        if (head_live) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!head_live) begin
          state_nx      = IDLE;
          starve_cnt_nx = '0;
        end else if (blocked) begin
          if (starve_cnt >= SCW'(STARVE_LIMIT - 1)) state_nx = STARVE;
          else starve_cnt_nx = starve_cnt + SCW'(1);
        end else begin
          starve_cnt_nx = '0;
        end
      end
      STARVE: begin
        if (!blocked) begin
          starve_cnt_nx = '0;
          state_nx      = others_live ? DRAIN : IDLE;
        end
      end
      default: begin
        state_nx      = IDLE;
        starve_cnt_nx = '0;
      end
    endcase
  end

endmodule
